// File: rtl/fsrcnn_pkg.sv
// fsrcnn_pkg: shared constants, drain FSM encoding and the requant helper for FSRCNN output stages
package fsrcnn_pkg;

    localparam int PSUM_W = 40;
    localparam int NUM_CH = 4;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } drain_state_t;

    localparam logic signed [PSUM_W:0] SAT_MAX = 41'sd32767;
    localparam logic signed [PSUM_W:0] SAT_MIN = -41'sd32768;

    // Round half up, arithmetic shift (capped at PSUM_W-1), then saturate to OUT_W signed.
    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [OUT_W-1:0] requant(input logic signed [PSUM_W-1:0] x,
                                                 input logic [5:0] shift);
        logic [5:0] sh;
        logic signed [PSUM_W:0] xe, rnd, y;
        sh  = (shift > 6'd39) ? 6'd39 : shift;
        xe  = {x[PSUM_W-1], x};
        rnd = (PSUM_W+1)'(1) << (sh - 6'd1);
        y   = (sh == 6'd0) ? xe : (xe + rnd) >>> sh;
        return (y > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
               (y < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : y[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/drain_fifo2.sv
// drain_fifo2: two-entry FIFO of {addr, data} with occupancy count; head is always presented
module drain_fifo2 #(
    parameter int W = 80
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wp, rp;

    assign head = mem[rp];

    // Storage and pointers; entries clear on reset so the outputs read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: streams a finished tile of 40-bit psums out of the buffer, requantized to 16 bits.
// Optional macro PSUM_DRAIN_RELU_EN fuses a ReLU after saturation.
module psum_drain
    import fsrcnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [15:0]              tile_size,
    input  logic [5:0]               shift,
    output logic                     re,
    output logic [ADDR_W-1:0]        ra,
    input  logic [NUM_CH*PSUM_W-1:0] rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*OUT_W-1:0]  out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     done
);

    drain_state_t             state;
    logic [ADDR_W-1:0]        base_q, issue_cnt, ra_q;
    logic [15:0]              size_q;
    logic [5:0]               shift_q;
    logic                     inflight, pop, flush_done;
    logic [1:0]               fifo_count;
    logic [2:0]               occ;
    logic [NUM_CH*OUT_W-1:0]  push_data;

    // A read may go out only if the word it returns is guaranteed a FIFO slot
    assign pop        = out_valid & out_ready;
    assign occ        = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign re         = (state == READ) && (occ < 3'd2);
    assign ra         = base_q + issue_cnt;
    assign flush_done = !inflight && (fifo_count == 2'(pop));
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign out_valid  = fifo_count != 2'd0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [OUT_W-1:0] q;
        assign q = requant(rd[k*PSUM_W +: PSUM_W], shift_q);
`ifdef PSUM_DRAIN_RELU_EN
        assign push_data[k*OUT_W +: OUT_W] = q[OUT_W-1] ? '0 : q;
`else
        assign push_data[k*OUT_W +: OUT_W] = q;
`endif
    end

    // Sequencer: latch tile parameters, walk the read addresses, drain, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base_q    <= '0;
            size_q    <= '0;
            shift_q   <= '0;
            issue_cnt <= '0;
            ra_q      <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= re;
            if (re) begin
                ra_q      <= ra;
                issue_cnt <= issue_cnt + 1'b1;
            end
            unique case (state)
                IDLE: if (start) begin
                    base_q    <= base_addr;
                    size_q    <= tile_size;
                    shift_q   <= shift;
                    issue_cnt <= '0;
                    state     <= READ;
                end
                READ:  if (re && issue_cnt == size_q) state <= FLUSH;
                FLUSH: if (flush_done) state <= DONE;
                DONE:  state <= IDLE;
            endcase
        end
    end

    drain_fifo2 #(.W(ADDR_W + NUM_CH*OUT_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({ra_q, push_data}),
        .pop       (pop),
        .head      ({out_addr, out_data}),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios for psum_drain with a behavioural psum buffer
module tb_psum_drain;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [15:0]  tile_size = '0;
    logic [5:0]   shift = '0;
    logic         re;
    logic [15:0]  ra;
    logic [159:0] rd = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  out_data;
    logic [15:0]  out_addr;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [159:0] bufmem [logic [15:0]];
    logic [79:0]  beats [$];
    logic [15:0]  ra_log [$];
    int           done_seen;
    bit           timed_out;

    int           mcount = 0, minfl = 0, credit_viol = 0, stab_viol = 0;
    logic         pv = 1'b0;
    logic [79:0]  pword = '0;

    psum_drain dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .tile_size(tile_size), .shift(shift), .re(re), .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [159:0] word_at(input logic [15:0] a);
        return bufmem.exists(a) ? bufmem[a] : {145'b0, a[14:0]};
    endfunction

    function automatic logic [79:0] dflt_beat(input logic [15:0] a);
        return {a, 48'b0, 1'b0, a[14:0]};
    endfunction

    function automatic logic rdy(input int c, input int mode);
        return (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
    endfunction

    always @(posedge clk) if (re) rd <= word_at(ra);

    // Independent occupancy model for the credit rule, plus stall-stability tracking
    always @(negedge clk) begin
        if (rst) begin
            mcount = 0;
            minfl  = 0;
            pv     = 1'b0;
        end else begin
            if (re && (mcount + minfl - int'(out_valid && out_ready)) >= 2) credit_viol++;
            if (pv && !(out_valid && {out_addr, out_data} == pword)) stab_viol++;
            if (re) ra_log.push_back(ra);
            mcount = mcount + minfl - int'(out_valid && out_ready);
            minfl  = int'(re);
            pv     = out_valid && !out_ready;
            pword  = {out_addr, out_data};
        end
    end

    task automatic run_drain(input logic [15:0] b, input logic [15:0] n, input logic [5:0] sh,
                             input int mode, input int stop, input int inj);
        beats.delete();
        ra_log.delete();
        done_seen = 0;
        timed_out = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = b; tile_size = n; shift = sh; out_ready = rdy(0, mode);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) beats.push_back({out_addr, out_data});
            if (done) done_seen++;
            if (done || (stop > 0 && beats.size() == stop)) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            start = (c + 1 == inj);
            if (c + 1 == inj) begin
                base_addr = 16'h0900;
                tile_size = 16'd0;
            end
            out_ready = rdy(c + 1, mode);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL reset_re got %b want 0", re); end
        checks++; if (ra !== 16'h0) begin errors++; $display("FAIL reset_ra got %h want 0000", ra); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (out_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", out_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) bufmem[16'h0010 + 16'(i)] = {120'b0, 40'(i + 1)};
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 16'h0010; tile_size = 16'd3; shift = 6'd0; out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (re !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL basic_re cycle %0d got %b want %b", c, re, c >= 1 && c <= 4); end
            checks++;
            if (out_valid !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL basic_valid cycle %0d got %b want %b", c, out_valid, c >= 3 && c <= 6); end
            checks++;
            if (done !== (c == 7)) begin errors++; $display("FAIL basic_done cycle %0d got %b want %b", c, done, c == 7); end
            checks++;
            if (busy !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL basic_busy cycle %0d got %b want %b", c, busy, c >= 1 && c <= 7); end
            if (c >= 3 && c <= 6) begin
                checks++;
                if ({out_addr, out_data} !== {16'h0010 + 16'(c - 3), 48'b0, 16'(c - 2)})
                    begin errors++; $display("FAIL basic_beat cycle %0d got %h_%h want %h_%h", c, out_addr, out_data, 16'h0010 + 16'(c - 3), 64'(c - 2)); end
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic test_rounding;
        logic [63:0] exp_d [3];
`ifdef PSUM_DRAIN_RELU_EN
        exp_d[0] = {16'h0000, 16'h7FFF, 16'h0000, 16'h0002};
        exp_d[1] = {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        exp_d[2] = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
`else
        exp_d[0] = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0002};
        exp_d[1] = {16'hFFFB, 16'h8000, 16'h7FFF, 16'h7FFF};
        exp_d[2] = {16'h0000, 16'h0000, 16'hFFFF, 16'h0001};
`endif
        bufmem[16'h0100] = {40'hF0_0000_0000, 40'h10_0000_0000, 40'hFF_FFFF_FFE8, 40'd24};
        bufmem[16'h0101] = {40'hFF_FFFF_FFFB, 40'hFF_FFFF_7FFF, 40'h00_0000_8000, 40'h00_0000_7FFF};
        bufmem[16'h0102] = {40'h0, 40'h0, 40'h80_0000_0000, 40'h7F_FFFF_FFFF};
        for (int t = 0; t < 3; t++) begin
            run_drain(16'h0100 + 16'(t), 16'd0, (t == 0) ? 6'd4 : (t == 1) ? 6'd0 : 6'd63, 0, 0, -1);
            checks++; if (timed_out) begin errors++; $display("FAIL round_timeout tile %0d got timeout want done", t); end
            checks++; if (beats.size() != 1) begin errors++; $display("FAIL round_count tile %0d got %0d want 1", t, beats.size()); end
            else begin
                checks++;
                if (beats[0] !== {16'h0100 + 16'(t), exp_d[t]})
                    begin errors++; $display("FAIL round_beat tile %0d got %h want %h", t, beats[0], {16'h0100 + 16'(t), exp_d[t]}); end
            end
        end
    endtask

    task automatic test_backpressure;
        credit_viol = 0;
        stab_viol = 0;
        run_drain(16'h0200, 16'd7, 6'd0, 1, 0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++;
            if (beats[i] !== dflt_beat(16'h0200 + 16'(i)))
                begin errors++; $display("FAIL bp_beat %0d got %h want %h", i, beats[i], dflt_beat(16'h0200 + 16'(i))); end
        end
        checks++; if (credit_viol != 0) begin errors++; $display("FAIL bp_credit got %0d violations want 0", credit_viol); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stab_viol); end
    endtask

    task automatic test_wrap_single;
        run_drain(16'hFFFF, 16'd1, 6'd0, 0, 0, -1);
        checks++; if (ra_log.size() != 2) begin errors++; $display("FAIL wrap_reads got %0d want 2", ra_log.size()); end
        else begin
            checks++; if (ra_log[0] !== 16'hFFFF) begin errors++; $display("FAIL wrap_ra0 got %h want ffff", ra_log[0]); end
            checks++; if (ra_log[1] !== 16'h0000) begin errors++; $display("FAIL wrap_ra1 got %h want 0000", ra_log[1]); end
        end
        checks++; if (beats.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", beats.size()); end
        else begin
            checks++; if (beats[0] !== dflt_beat(16'hFFFF)) begin errors++; $display("FAIL wrap_beat0 got %h want %h", beats[0], dflt_beat(16'hFFFF)); end
            checks++; if (beats[1] !== dflt_beat(16'h0000)) begin errors++; $display("FAIL wrap_beat1 got %h want %h", beats[1], dflt_beat(16'h0000)); end
        end
        run_drain(16'h0030, 16'd0, 6'd0, 0, 0, -1);
        checks++; if (done_seen != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_seen); end
        checks++; if (beats.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", beats.size()); end
        else begin
            checks++; if (beats[0] !== dflt_beat(16'h0030)) begin errors++; $display("FAIL single_beat got %h want %h", beats[0], dflt_beat(16'h0030)); end
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        run_drain(16'h0300, 16'd15, 6'd0, 0, 2, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL rmid_timeout got timeout want 2 beats"); end
        #1 rst = 1'b1;
        #1;
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL rmid_re got %b want 0", re); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rmid_data got %h want 0", out_data); end
        checks++; if (out_addr !== 16'h0) begin errors++; $display("FAIL rmid_addr got %h want 0000", out_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle cycle %0d got done %b busy %b want 0 0", c, done, busy); end
        end
        run_drain(16'h0040, 16'd2, 6'd0, 0, 0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL rmid_restart_timeout got timeout want done"); end
        checks++; if (beats.size() != 3) begin errors++; $display("FAIL rmid_restart_count got %0d want 3", beats.size()); end
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            checks++;
            if (beats[i] !== dflt_beat(16'h0040 + 16'(i)))
                begin errors++; $display("FAIL rmid_restart_beat %0d got %h want %h", i, beats[i], dflt_beat(16'h0040 + 16'(i))); end
        end
    endtask

    task automatic test_ignored_start;
        run_drain(16'h0080, 16'd5, 6'd0, 0, 0, 2);
        checks++; if (timed_out) begin errors++; $display("FAIL ign_timeout got timeout want done"); end
        checks++; if (beats.size() != 6) begin errors++; $display("FAIL ign_count got %0d want 6", beats.size()); end
        for (int i = 0; i < beats.size() && i < 6; i++) begin
            checks++;
            if (beats[i] !== dflt_beat(16'h0080 + 16'(i)))
                begin errors++; $display("FAIL ign_beat %0d got %h want %h", i, beats[i], dflt_beat(16'h0080 + 16'(i))); end
        end
        start = 1'b1; base_addr = 16'h0A00; tile_size = 16'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || re !== 1'b0) begin errors++; $display("FAIL ign_done_start cycle %0d got busy %b re %b want 0 0", c, busy, re); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_backpressure;
        test_wrap_single;
        test_reset_mid;
        test_ignored_start;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
